// File: rtl/l4_feature_streamer.sv
//==============================================================================
// Module      : l4_feature_streamer
// Description : Reads both layer-4 pooled-feature memories through one shared
//               address and streams the 400 flattened words over valid/ready.
//               A credit rule covers the read-latency pipe plus a small FWFT
//               FIFO, so the FIFO cannot overflow under backpressure.
//               Optional macro: L4_STREAM_RELU_EN (clamp negative words to 0).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module l4_feature_streamer #(
  parameter int DATA_WIDTH = 12,
  parameter int BANK_DEPTH = 200,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_WIDTH  = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  L5_en,
  output logic [7:0]            L4_output_read_addr,
  input  logic [DATA_WIDTH-1:0] L4_output_read_data1,
  input  logic [DATA_WIDTH-1:0] L4_output_read_data2,
  output logic [DATA_WIDTH-1:0] feat_data,
  output logic                  feat_valid,
  input  logic                  feat_ready,
  output logic [IDX_WIDTH-1:0]  feat_index,
  output logic                  feat_last,
  output logic                  L5_feed_done
);

  localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(2 * BANK_DEPTH - 1);
  localparam logic [7:0]           ADDR_MAX = 8'(BANK_DEPTH - 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_DRAIN = 4'b0100,
    S_DONE  = 4'b1000
  } state_t;

  state_t                 state_q;
  logic [7:0]             addr_q;
  logic                   bank_q;
  logic                   last_seen_q;

  logic [RD_LATENCY-1:0]  pv_q;
  logic                   pb_q [RD_LATENCY];
  logic [IDX_WIDTH-1:0]   pi_q [RD_LATENCY];

  logic [DATA_WIDTH-1:0]  fd_q [FIFO_DEPTH];
  logic [IDX_WIDTH-1:0]   fi_q [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q;
  logic [PW-1:0]          rd_ptr_q;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;
  logic                   valid_q;

  logic                   w_abort;
  logic                   w_issue;
  logic                   w_push;
  logic                   w_pop;
  logic [CW-1:0]          w_inflight;
  logic [IDX_WIDTH-1:0]   w_issue_idx;
  logic [DATA_WIDTH-1:0]  w_push_data;
  logic [DATA_WIDTH-1:0]  w_head;
  logic [DATA_WIDTH-1:0]  w_word;

  // Credit accounting: count reads in flight and decide whether to issue
  always_comb begin
    w_inflight = '0;
    for (int k = 0; k < RD_LATENCY; k++) begin
      w_inflight = w_inflight + CW'(pv_q[k]);
    end
    w_abort     = !L5_en && ((state_q == S_ISSUE) || (state_q == S_DRAIN));
    w_issue     = (state_q == S_ISSUE) && L5_en &&
                  ((count_q + w_inflight) < CW'(FIFO_DEPTH));
    w_issue_idx = bank_q ? (IDX_WIDTH'(BANK_DEPTH) + IDX_WIDTH'(addr_q))
                         : IDX_WIDTH'(addr_q);
    w_push      = pv_q[RD_LATENCY-1];
    w_push_data = pb_q[RD_LATENCY-1] ? L4_output_read_data2 : L4_output_read_data1;
    w_pop       = valid_q && feat_ready;
    count_d     = count_q + CW'(w_push) - CW'(w_pop);
  end

  // Control FSM: walks bank 0 then bank 1, then waits for the stream to drain
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      bank_q      <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      if (w_pop && (fi_q[rd_ptr_q] == LAST_IDX)) begin
        last_seen_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          addr_q      <= '0;
          bank_q      <= 1'b0;
          last_seen_q <= 1'b0;
          if (L5_en) state_q <= S_ISSUE;
        end
        S_ISSUE: begin
          if (!L5_en) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            bank_q      <= 1'b0;
            last_seen_q <= 1'b0;
          end else if (w_issue) begin
            if (addr_q == ADDR_MAX) begin
              addr_q <= '0;
              if (bank_q) begin
                bank_q  <= 1'b0;
                state_q <= S_DRAIN;
              end else begin
                bank_q <= 1'b1;
              end
            end else begin
              addr_q <= addr_q + 8'd1;
            end
          end
        end
        S_DRAIN: begin
          if (!L5_en) begin
            state_q     <= S_IDLE;
            last_seen_q <= 1'b0;
          end else if ((w_inflight == '0) && (count_q == '0) && last_seen_q) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (!L5_en) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Read-latency pipe: carries valid, bank select and index alongside the RAM read
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
        pb_q[k] <= 1'b0;
        pi_q[k] <= '0;
      end
    end else begin
      pv_q[0] <= w_issue && !w_abort;
      pb_q[0] <= bank_q;
      pi_q[0] <= w_issue_idx;
      for (int k = 1; k < RD_LATENCY; k++) begin
        pv_q[k] <= pv_q[k-1];
        pb_q[k] <= pb_q[k-1];
        pi_q[k] <= pi_q[k-1];
      end
      if (w_abort) pv_q <= '0;
    end
  end

  // Output FIFO: first-word-fall-through, flushed on reset or abort
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fd_q[k] <= '0;
        fi_q[k] <= '0;
      end
    end else if (w_abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (w_push) begin
        fd_q[wr_ptr_q] <= w_push_data;
        fi_q[wr_ptr_q] <= pi_q[RD_LATENCY-1];
        wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  // Head-of-FIFO word, optionally clamped to zero when negative
  always_comb begin
    w_head = fd_q[rd_ptr_q];
`ifdef L4_STREAM_RELU_EN
    w_word = w_head[DATA_WIDTH-1] ? '0 : w_head;
`else
    w_word = w_head;
`endif
  end

  assign L4_output_read_addr = addr_q;
  assign feat_valid          = valid_q;
  assign feat_data           = valid_q ? w_word : '0;
  assign feat_index          = valid_q ? fi_q[rd_ptr_q] : '0;
  assign feat_last           = valid_q && (fi_q[rd_ptr_q] == LAST_IDX);
  assign L5_feed_done        = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_l4_feature_streamer.sv
//==============================================================================
// Module      : tb_l4_feature_streamer
// Description : Self-checking bench for l4_feature_streamer with a 2-cycle
//               RAM model and a flat-index reference of the expected stream.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_l4_feature_streamer;

  logic        clk;
  logic        rst;
  logic        L5_en;
  logic [7:0]  addr;
  logic [11:0] rd1;
  logic [11:0] rd2;
  logic [11:0] feat_data;
  logic        feat_valid;
  logic        feat_ready;
  logic [8:0]  feat_index;
  logic        feat_last;
  logic        L5_feed_done;

  l4_feature_streamer dut (
    .clk                  (clk),
    .rst                  (rst),
    .L5_en                (L5_en),
    .L4_output_read_addr  (addr),
    .L4_output_read_data1 (rd1),
    .L4_output_read_data2 (rd2),
    .feat_data            (feat_data),
    .feat_valid           (feat_valid),
    .feat_ready           (feat_ready),
    .feat_index           (feat_index),
    .feat_last            (feat_last),
    .L5_feed_done         (L5_feed_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block-RAM model: two registered stages from address to data
  logic [11:0] mem1 [200];
  logic [11:0] mem2 [200];
  logic [7:0]  ra_q;
  always @(posedge clk) begin
    ra_q <= addr;
    rd1  <= (ra_q < 8'd200) ? mem1[ra_q] : 12'h000;
    rd2  <= (ra_q < 8'd200) ? mem2[ra_q] : 12'h000;
  end

  typedef struct {
    int          idx;
    logic [11:0] data;
    logic        last;
  } vec_t;
  vec_t tbl [7];

  int          n_tests, n_fail;
  int          exp_n, tick_no, first_valid_tick, last_hs_tick, wraps;
  int          rmode, stall_idx, stall_left;
  logic        prev_stall;
  logic [11:0] prev_data;
  logic [8:0]  prev_index;
  logic [7:0]  prev_addr, frz_addr;
  logic [11:0] cap_data [400];
  logic        cap_last [400];

  function automatic logic [11:0] model_word(input int idx);
    logic [11:0] w;
    w = (idx < 200) ? mem1[idx] : mem2[idx-200];
`ifdef L4_STREAM_RELU_EN
    if (w[11]) w = 12'h000;
`endif
    return w;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic observe();
    if (prev_addr == 8'd199 && addr == 8'd0) wraps++;
    prev_addr = addr;
    if (prev_stall) begin
      chk("stall_valid", int'(feat_valid), 1);
      chk("stall_data", int'(feat_data), int'(prev_data));
      chk("stall_index", int'(feat_index), int'(prev_index));
    end
    if (feat_valid && first_valid_tick < 0) first_valid_tick = tick_no;
    if (feat_valid && feat_ready) begin
      if (exp_n >= 400) begin
        chk("overrun", exp_n, 399);
      end else begin
        chk("index", int'(feat_index), exp_n);
        chk("data", int'(feat_data), int'(model_word(exp_n)));
        chk("last", int'(feat_last), (exp_n == 399) ? 1 : 0);
        cap_data[exp_n] = feat_data;
        cap_last[exp_n] = feat_last;
      end
      exp_n++;
      last_hs_tick = tick_no;
    end
    prev_stall = feat_valid && !feat_ready;
    prev_data  = feat_data;
    prev_index = feat_index;
  endtask

  task automatic tick();
    logic r;
    @(negedge clk);
    tick_no++;
    case (rmode)
      0:       r = 1'b1;
      1:       r = tick_no[0];
      default: r = ($urandom_range(0, 3) != 0);
    endcase
    if (stall_left == 0 && stall_idx >= 0 && feat_valid && int'(feat_index) == stall_idx) begin
      stall_left = 20;
      stall_idx  = -1;
    end
    if (stall_left > 0) begin
      r = 1'b0;
      stall_left--;
      if (stall_left == 14) frz_addr = addr;
      if (stall_left == 0) chk("addr_frozen", int'(addr), int'(frz_addr));
    end
    feat_ready = r;
    observe();
  endtask

  task automatic begin_run(input int mode);
    rmode = mode; exp_n = 0; tick_no = 0; first_valid_tick = -1;
    last_hs_tick = -1; wraps = 0; prev_stall = 1'b0;
    L5_en = 1'b1;
  endtask

  task automatic run_done(input int bound);
    int k;
    k = 0;
    while (!L5_feed_done && k < bound) begin
      tick();
      k++;
    end
    chk("done_reached", int'(L5_feed_done), 1);
    chk("word_count", exp_n, 400);
  endtask

  task automatic stop_run();
    L5_en = 1'b0;
    tick();
    chk("done_clear", int'(L5_feed_done), 0);
    chk("idle_valid", int'(feat_valid), 0);
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 200; i++) begin
      mem1[i] = 12'(i);
      mem2[i] = 12'(i + 'h200);
    end
  endtask

  initial begin
    int k;
    n_tests = 0; n_fail = 0;
    rst = 1'b1; L5_en = 1'b0; feat_ready = 1'b0;
    rmode = 0; stall_idx = -1; stall_left = 0; prev_stall = 1'b0;
    prev_addr = '0; frz_addr = '0; prev_data = '0; prev_index = '0;
    exp_n = 0; tick_no = 0; first_valid_tick = -1; last_hs_tick = -1; wraps = 0;
    tbl[0] = '{0,   12'h000, 1'b0};
    tbl[1] = '{1,   12'h001, 1'b0};
    tbl[2] = '{150, 12'h096, 1'b0};
    tbl[3] = '{199, 12'h0C7, 1'b0};
    tbl[4] = '{200, 12'h200, 1'b0};
    tbl[5] = '{201, 12'h201, 1'b0};
    tbl[6] = '{399, 12'h2C7, 1'b1};
    load_pattern();

    // Reset state
    repeat (3) tick();
    chk("rst_valid", int'(feat_valid), 0);
    chk("rst_data", int'(feat_data), 0);
    chk("rst_index", int'(feat_index), 0);
    chk("rst_last", int'(feat_last), 0);
    chk("rst_done", int'(L5_feed_done), 0);
    chk("rst_addr", int'(addr), 0);
    rst = 1'b0;
    tick();

    // Full stream with ready held high: latency, throughput, bank boundary
    begin_run(0);
    run_done(3000);
    chk("first_valid_latency", first_valid_tick - 1, 3);
    chk("last_word_tick", last_hs_tick, 403);
    chk("addr_wraps", wraps, 2);
    repeat (3) tick();
    chk("done_hold", int'(L5_feed_done), 1);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("tbl_data[%0d]", tbl[i].idx), int'(cap_data[tbl[i].idx]), int'(tbl[i].data));
      chk($sformatf("tbl_last[%0d]", tbl[i].idx), int'(cap_last[tbl[i].idx]), int'(tbl[i].last));
    end
    stop_run();

    // Toggled ready plus a 20-cycle stall at index 150
    stall_idx = 150;
    begin_run(1);
    run_done(3000);
    stop_run();

    // Abort at index 250, then restart from zero
    begin_run(0);
    k = 0;
    while (exp_n <= 250 && k < 2000) begin tick(); k++; end
    chk("reach_idx250", (exp_n > 250) ? 1 : 0, 1);
    L5_en = 1'b0;
    prev_stall = 1'b0;
    tick();
    chk("abort_valid", int'(feat_valid), 0);
    chk("abort_addr", int'(addr), 0);
    chk("abort_done", int'(L5_feed_done), 0);
    repeat (3) tick();
    chk("abort_valid_hold", int'(feat_valid), 0);
    begin_run(0);
    run_done(3000);
    stop_run();

    // Reset pulse during drain, then a complete run
    begin_run(0);
    k = 0;
    while (exp_n < 398 && k < 2000) begin tick(); k++; end
    chk("reach_idx398", (exp_n >= 398) ? 1 : 0, 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", int'(feat_valid), 0);
    chk("mid_rst_data", int'(feat_data), 0);
    chk("mid_rst_index", int'(feat_index), 0);
    chk("mid_rst_last", int'(feat_last), 0);
    chk("mid_rst_done", int'(L5_feed_done), 0);
    chk("mid_rst_addr", int'(addr), 0);
    rst = 1'b0;
    begin_run(0);
    run_done(3000);
    stop_run();

    // Random memory contents and random backpressure, negative word at index 5
    for (int i = 0; i < 200; i++) begin
      mem1[i] = 12'($urandom);
      mem2[i] = 12'($urandom);
    end
    mem1[5] = 12'h800;
    begin_run(2);
    run_done(5000);
`ifdef L4_STREAM_RELU_EN
    chk("relu_word", int'(cap_data[5]), 'h000);
`else
    chk("relu_word", int'(cap_data[5]), 'h800);
`endif
    stop_run();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
